// File: rtl/exhaustive_stim_gen_if.sv
// Handshake and data bundle between the exhaustive stimulus generator and
// its controller / block under test.
interface exhaustive_stim_gen_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2
);
  logic             start;
  logic             abort;
  logic [IN_W-1:0]  vec_out;
  logic             vec_valid;
  logic [OUT_W-1:0] resp_in;
  logic             busy;
  logic             done;
  logic [IN_W:0]    vec_count;
  logic [15:0]      signature;

  modport master (
    input  start, abort, resp_in,
    output vec_out, vec_valid, busy, done, vec_count, signature
  );

  modport slave (
    output start, abort, resp_in,
    input  vec_out, vec_valid, busy, done, vec_count, signature
  );
endinterface

// File: rtl/exhaustive_stim_gen.sv
// Exhaustive stimulus sequencer with response compaction into a 16-bit signature.
// Define EXHAUSTIVE_STIM_MISR_EN for a MISR signature; otherwise an additive checksum.
module exhaustive_stim_gen #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 2,
  parameter int SETTLE = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  exhaustive_stim_gen_if.master bus
);

  localparam int WC_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  localparam logic [WC_W-1:0] WC_ONE   = 1;
  localparam logic [WC_W-1:0] WC_LAST  = WC_W'(SETTLE - 1);
  localparam logic [IN_W-1:0] VEC_ONE  = 1;
  localparam logic [IN_W-1:0] VEC_LAST = '1;
  localparam logic [IN_W:0]   CNT_ONE  = 1;

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [WC_W-1:0] wait_cnt;
  logic [IN_W-1:0] vec_reg;
  logic [IN_W:0]   count_reg;
  logic [15:0]     sig_reg;
  logic [15:0]     sig_next;
  logic [15:0]     resp_ext;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;
  logic            settle_hit;
  logic            last_vec;

  assign resp_ext   = 16'(bus.resp_in);
  assign settle_hit = (wait_cnt == WC_LAST);
  assign last_vec   = (vec_reg == VEC_LAST);

`ifdef EXHAUSTIVE_STIM_MISR_EN
  // Taps for x^16+x^14+x^13+x^11+1, response XORed in after the shift.
  assign sig_next = {sig_reg[14:0], sig_reg[15] ^ sig_reg[13] ^ sig_reg[12] ^ sig_reg[10]} ^ resp_ext;
`else
  assign sig_next = sig_reg + resp_ext;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    valid_q    = 1'b0;
    busy_q     = 1'b0;
    done_q     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start)
          state_next = WAIT;
      end
      WAIT: begin
        valid_q = 1'b1;
        busy_q  = 1'b1;
        if (settle_hit)
          state_next = CAPTURE;
      end
      CAPTURE: begin
        valid_q    = 1'b1;
        busy_q     = 1'b1;
        state_next = last_vec ? DONE : WAIT;
      end
      DONE: begin
        done_q = 1'b1;
        if (bus.start)
          state_next = WAIT;
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides every transition, including a simultaneous start.
    if (bus.abort)
      state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || bus.abort) begin
      wait_cnt  <= '0;
      vec_reg   <= '0;
      count_reg <= '0;
      sig_reg   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            wait_cnt  <= '0;
            vec_reg   <= '0;
            count_reg <= '0;
            sig_reg   <= '0;
          end
        end
        WAIT: wait_cnt <= wait_cnt + WC_ONE;
        CAPTURE: begin
          sig_reg   <= sig_next;
          count_reg <= count_reg + CNT_ONE;
          if (!last_vec) begin
            vec_reg  <= vec_reg + VEC_ONE;
            wait_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.vec_out   = vec_reg;
  assign bus.vec_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.vec_count = count_reg;
  assign bus.signature = sig_reg;

endmodule
